mem_stage_lsu: RTL and testbench

//  MEM pipeline stage of the 5-stage MIPS core, directly downstream of EX: holds the EX->MEM pipeline register.
//  It owns the data-SRAM request/response handshake for loads and stores, and does sub-word store merging and load extraction/extension.

---
 rtl/mem_stage_lsu.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM stage of the 5-stage MIPS core.
//
// Holds the EX->MEM pipeline register and runs the data-SRAM request/response
// handshake for loads and stores. Stores are merged into byte strobes with
// replicated write data. Load data is extracted from the returned word and then
// sign- or zero-extended. While an access is outstanding the stage requests a
// stall of stages 0..4.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   When it is defined, misaligned half/word accesses issue no request. They go
//   straight to DONE, drop rf_we and raise mem_excp while the record is held.
//   When it is undefined, no alignment check is made and mem_excp is tied 0.
//
// Ports
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   stall[5:0]           pipeline stall vector, 1 = stop; uses [3] (own) and [4] (WB)
//   ex_to_mem_bus[107:0] {pc, mem_en, mem_we, mem_size, mem_uns, sel_rf_res,
//                         rf_we, rf_waddr, ex_result, store_data}
//   mem_to_wb_bus[69:0]  {pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_rf_bus[37:0]  forwarding {rf_we, rf_waddr, rf_wdata}
//   stallreq_for_mem     1 while an access is in REQ or WAIT
//   data_req/wr/size/wstrb/addr/wdata   SRAM request side
//   data_addr_ok/data_ok/rdata          SRAM response side
//   mem_excp             misalignment flag (alignment-check build only)
module mem_stage_lsu #(
  parameter int EX_TO_MEM_WD = 108,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_rf_bus,
  output logic                    stallreq_for_mem,
  output logic                    data_req,
  output logic                    data_wr,
  output logic [1:0]              data_size,
  output logic [3:0]              data_wstrb,
  output logic [31:0]             data_addr,
  output logic [31:0]             data_wdata,
  input  logic                    data_addr_ok,
  input  logic                    data_data_ok,
  input  logic [31:0]             data_rdata,
  output logic                    mem_excp
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                  r_state;
  logic [EX_TO_MEM_WD-1:0] r_ex_mem;
  logic [31:0]             r_load;

  logic        w_adv, w_bubble;
  logic [31:0] w_pc, w_ex_result, w_store_data, w_load_val, w_rf_wdata;
  logic        w_mem_en, w_mem_we, w_mem_uns, w_sel_rf_res, w_rf_we_raw, w_rf_we;
  logic [1:0]  w_mem_size;
  logic [4:0]  w_rf_waddr;
  logic        w_misal, w_in_misal;
  state_t      w_next_on_load;
  logic        w_unused_stall;

  assign w_adv    = ~stall[3];
  assign w_bubble = stall[3] & ~stall[4];
  assign w_unused_stall = ^{stall[STALL_WD-1:5], stall[2:0]};

  assign w_pc         = r_ex_mem[107:76];
  assign w_mem_en     = r_ex_mem[75];
  assign w_mem_we     = r_ex_mem[74];
  assign w_mem_size   = r_ex_mem[73:72];
  assign w_mem_uns    = r_ex_mem[71];
  assign w_sel_rf_res = r_ex_mem[70];
  assign w_rf_we_raw  = r_ex_mem[69];
  assign w_rf_waddr   = r_ex_mem[68:64];
  assign w_ex_result  = r_ex_mem[63:32];
  assign w_store_data = r_ex_mem[31:0];

  function automatic logic [3:0] f_wstrb(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] sd);
    case (sz)
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] f_load_ext(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a != 2'b00));
  endfunction

  assign w_misal    = w_mem_en & f_misaligned(w_mem_size, w_ex_result[1:0]);
  assign w_in_misal = ex_to_mem_bus[75] & f_misaligned(ex_to_mem_bus[73:72], ex_to_mem_bus[33:32]);
`else
  assign w_misal    = 1'b0;
  assign w_in_misal = 1'b0;
`endif

  // A misaligned record skips the bus entirely and is presented as finished.
  assign w_next_on_load = !ex_to_mem_bus[75] ? S_IDLE : (w_in_misal ? S_DONE : S_REQ);

  // stage boundary: EX->MEM register and access FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ex_mem <= '0;
      r_state  <= S_IDLE;
      r_load   <= '0;
    end else begin
      if (w_bubble)   r_ex_mem <= '0;
      else if (w_adv) r_ex_mem <= ex_to_mem_bus;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_bubble)   r_state <= S_IDLE;
          else if (w_adv) r_state <= w_next_on_load;
        end
        S_REQ: begin
          if (data_addr_ok) begin
            if (data_data_ok) begin
              r_load  <= data_rdata;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            r_load  <= data_rdata;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stallreq_for_mem = (r_state == S_REQ) || (r_state == S_WAIT);
  assign data_req         = (r_state == S_REQ);
  assign data_wr          = w_mem_we;
  assign data_size        = w_mem_size;
  assign data_addr        = w_ex_result;
  assign data_wstrb       = w_mem_we ? f_wstrb(w_mem_size, w_ex_result[1:0]) : 4'b0000;
  assign data_wdata       = f_wdata(w_mem_size, w_store_data);
  assign mem_excp         = w_misal;

  assign w_load_val = f_load_ext(r_load, w_ex_result[1:0], w_mem_size, w_mem_uns);
  assign w_rf_wdata = w_sel_rf_res ? w_load_val : w_ex_result;

  // Stores never write the RF, and a memory op only exposes rf_we once finished.
  assign w_rf_we = w_rf_we_raw & ~(w_mem_en & w_mem_we) & ~w_misal
                 & (~w_mem_en | (r_state == S_DONE));

  assign mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
  assign mem_to_rf_bus = {w_rf_we, w_rf_waddr, w_rf_wdata};

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic         clk = 1'b0;
  logic         resetn;
  logic [5:0]   stall;
  logic [107:0] ex_to_mem_bus;
  logic [69:0]  mem_to_wb_bus;
  logic [37:0]  mem_to_rf_bus;
  logic         stallreq_for_mem, data_req, data_wr;
  logic [1:0]   data_size;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_addr, data_wdata;
  logic         data_addr_ok, data_data_ok;
  logic [31:0]  data_rdata;
  logic         mem_excp;
  logic         tb_s3, tb_s4;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [69:0] sb_q[$];

  always #5 clk = ~clk;

  // Stall controller: own stall request holds stages 0..4; tb_s3/tb_s4 add external holds.
  assign stall = {1'b0, tb_s4 | stallreq_for_mem, tb_s3 | stallreq_for_mem, {3{stallreq_for_mem}}};

  mem_stage_lsu dut (
    .clk(clk), .resetn(resetn), .stall(stall), .ex_to_mem_bus(ex_to_mem_bus),
    .mem_to_wb_bus(mem_to_wb_bus), .mem_to_rf_bus(mem_to_rf_bus),
    .stallreq_for_mem(stallreq_for_mem), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_excp(mem_excp)
  );

  function automatic logic [107:0] mk(input logic [31:0] pc, input logic en, input logic we,
                                      input logic [1:0] sz, input logic uns, input logic sel,
                                      input logic rfwe, input logic [4:0] wa,
                                      input logic [31:0] res, input logic [31:0] sd);
    return {pc, en, we, sz, uns, sel, rfwe, wa, res, sd};
  endfunction

  // Drive one record at posedge+1; it is loaded at the next edge. Expected WB bus queued.
  task automatic issue(input logic [107:0] rec, input logic [69:0] exp);
    sb_q.push_back(exp);
    ex_to_mem_bus = rec;
    @(posedge clk); #1;
    ex_to_mem_bus = '0;
  endtask

  // SRAM responder: addr_ok after aw wait cycles, data_ok dw cycles after acceptance.
  task automatic run_sram(input int aw, input int dw, input logic [31:0] rdata,
                          output int ncyc, output bit stable, output bit fwd_bad,
                          output bit timeout);
    logic [70:0] snap;
    int k, w;
    k = 0; w = 0; ncyc = 0; stable = 1'b1; fwd_bad = 1'b0; timeout = 1'b0;
    snap = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
    while (stallreq_for_mem) begin
      if (ncyc > 200) begin timeout = 1'b1; break; end
      ncyc++;
      if (mem_to_rf_bus[37]) fwd_bad = 1'b1;
      if (data_req) begin
        if ({data_wr, data_size, data_wstrb, data_addr, data_wdata} !== snap) stable = 1'b0;
        if (k >= aw) begin
          data_addr_ok = 1'b1;
          w = 1;
          if (dw == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
        end else k++;
      end else begin
        if (w >= dw) begin data_data_ok = 1'b1; data_rdata = rdata; end
        else w++;
      end
      @(posedge clk); #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    end
  endtask

  task automatic test_reset();
    int nc; bit st, fb, to;
    #2;
    n_cmp++; if ({data_req, stallreq_for_mem, data_wstrb, mem_excp} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0", {data_req, stallreq_for_mem, data_wstrb, mem_excp}); end
    n_cmp++; if ({mem_to_wb_bus, mem_to_rf_bus} !== 108'b0) begin
      n_fail++; $display("FAIL reset_buses got %h exp 0", {mem_to_wb_bus, mem_to_rf_bus}); end
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1;
    issue(mk(32'h0000_0400, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd3, 32'h100, 32'h0), 70'h0);
    data_addr_ok = 1'b1;
    @(posedge clk); #1; data_addr_ok = 1'b0;
    n_cmp++; if (stallreq_for_mem !== 1'b1) begin
      n_fail++; $display("FAIL reset_wait_stall got %b exp 1", stallreq_for_mem); end
    #2; resetn = 1'b0; #1;
    n_cmp++; if ({data_req, stallreq_for_mem} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_ctrl got %b exp 00", {data_req, stallreq_for_mem}); end
    n_cmp++; if ({mem_to_wb_bus, mem_to_rf_bus} !== 108'b0) begin
      n_fail++; $display("FAIL reset_mid_buses got %h exp 0", {mem_to_wb_bus, mem_to_rf_bus}); end
    sb_q.delete();
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({data_req, stallreq_for_mem, mem_to_rf_bus[37]} !== 3'b000) begin
      n_fail++; $display("FAIL reset_after_idle got %b exp 000", {data_req, stallreq_for_mem, mem_to_rf_bus[37]}); end
    run_sram(0, 0, 32'h0, nc, st, fb, to);
  endtask

  task automatic test_lw();
    int nc; bit st, fb, to; logic [69:0] exp;
    issue(mk(32'h0000_0404, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd3, 32'h100, 32'h0),
          {32'h0000_0404, 1'b1, 5'd3, 32'hDEAD_BEEF});
    n_cmp++; if ({data_req, data_wr, data_size, data_wstrb, data_addr} !== {1'b1, 1'b0, 2'b10, 4'b0, 32'h100}) begin
      n_fail++; $display("FAIL lw_req got %h exp %h", {data_req, data_wr, data_size, data_wstrb, data_addr},
                         {1'b1, 1'b0, 2'b10, 4'b0, 32'h100}); end
    run_sram(0, 1, 32'hDEAD_BEEF, nc, st, fb, to);
    n_cmp++; if ({to, nc} !== {1'b0, 32'd2}) begin
      n_fail++; $display("FAIL lw_stall_cycles got %0d (timeout %0d) exp 2", nc, to); end
    n_cmp++; if (fb !== 1'b0) begin
      n_fail++; $display("FAIL lw_early_fwd got %b exp 0", fb); end
    exp = sb_q.pop_front();
    n_cmp++; if (mem_to_wb_bus !== exp) begin
      n_fail++; $display("FAIL lw_wb got %h exp %h", mem_to_wb_bus, exp); end
    n_cmp++; if (mem_to_rf_bus !== exp[37:0]) begin
      n_fail++; $display("FAIL lw_fwd got %h exp %h", mem_to_rf_bus, exp[37:0]); end
  endtask

  task automatic test_load_extend();
    int nc; bit st, fb, to; logic [69:0] exp;
    logic [31:0] a_t [0:6];
    logic [1:0]  s_t [0:6];
    logic        u_t [0:6];
    logic [31:0] e_t [0:6];
    a_t = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
    s_t = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    u_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    e_t = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_8011,
            32'h0000_0033, 32'h0000_0022, 32'h0000_2233};
    for (int i = 0; i < 7; i++) begin
      issue(mk(32'(32'h500 + 4 * i), 1'b1, 1'b0, s_t[i], u_t[i], 1'b1, 1'b1, 5'(i + 1), a_t[i], 32'hFFFF_FFFF),
            {32'(32'h500 + 4 * i), 1'b1, 5'(i + 1), e_t[i]});
      n_cmp++; if ({data_req, data_wr, data_size, data_wstrb, data_addr} !== {1'b1, 1'b0, s_t[i], 4'b0, a_t[i]}) begin
        n_fail++; $display("FAIL load_req[%0d] got %h exp %h", i,
                           {data_req, data_wr, data_size, data_wstrb, data_addr}, {1'b1, 1'b0, s_t[i], 4'b0, a_t[i]}); end
      run_sram(i % 2, i % 3, 32'h8011_2233, nc, st, fb, to);
      exp = sb_q.pop_front();
      n_cmp++; if ({to, mem_to_wb_bus} !== {1'b0, exp}) begin
        n_fail++; $display("FAIL load_ext[%0d] got %h exp %h (timeout %0d)", i, mem_to_wb_bus, exp, to); end
    end
  endtask

  task automatic test_store_merge();
    int nc; bit st, fb, to; logic [69:0] exp;
    logic [31:0] a_t [0:4];
    logic [1:0]  s_t [0:4];
    logic [31:0] d_t [0:4];
    logic [3:0]  b_t [0:4];
    logic [31:0] w_t [0:4];
    a_t = '{32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
    s_t = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
    d_t = '{32'h0000_00A5, 32'h0000_BEEF, 32'h1234_5678, 32'h1234_565A, 32'h9999_CAFE};
    b_t = '{4'b0100, 4'b1100, 4'b1111, 4'b0010, 4'b0011};
    w_t = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h1234_5678, 32'h5A5A_5A5A, 32'hCAFE_CAFE};
    for (int i = 0; i < 5; i++) begin
      issue(mk(32'(32'h600 + 4 * i), 1'b1, 1'b1, s_t[i], 1'b0, 1'b0, 1'b1, 5'd9, a_t[i], d_t[i]),
            {32'(32'h600 + 4 * i), 1'b0, 5'd9, a_t[i]});
      n_cmp++; if ({data_req, data_wr, data_size, data_wstrb, data_wdata} !== {1'b1, 1'b1, s_t[i], b_t[i], w_t[i]}) begin
        n_fail++; $display("FAIL store_req[%0d] got %h exp %h", i,
                           {data_req, data_wr, data_size, data_wstrb, data_wdata}, {1'b1, 1'b1, s_t[i], b_t[i], w_t[i]}); end
      run_sram(0, 1, 32'hFFFF_FFFF, nc, st, fb, to);
      exp = sb_q.pop_front();
      n_cmp++; if ({to, mem_to_wb_bus, mem_to_rf_bus[37]} !== {1'b0, exp, 1'b0}) begin
        n_fail++; $display("FAIL store_result[%0d] got %h/%b exp %h/0", i, mem_to_wb_bus, mem_to_rf_bus[37], exp); end
    end
  endtask

  task automatic test_non_mem();
    logic [69:0] exp;
    issue(mk(32'h700, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234_5678, 32'h0),
          {32'h700, 1'b1, 5'd7, 32'h1234_5678});
    exp = sb_q.pop_front();
    n_cmp++; if ({data_req, stallreq_for_mem} !== 2'b00) begin
      n_fail++; $display("FAIL alu_ctrl got %b exp 00", {data_req, stallreq_for_mem}); end
    n_cmp++; if ({mem_to_wb_bus, mem_to_rf_bus} !== {exp, exp[37:0]}) begin
      n_fail++; $display("FAIL alu_result got %h/%h exp %h", mem_to_wb_bus, mem_to_rf_bus, exp); end
  endtask

  task automatic test_backpressure();
    int nc; bit st, fb, to; logic [69:0] exp;
    issue(mk(32'h800, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd12, 32'h200, 32'h0),
          {32'h800, 1'b1, 5'd12, 32'h0BAD_F00D});
    run_sram(3, 4, 32'h0BAD_F00D, nc, st, fb, to);
    n_cmp++; if (st !== 1'b1) begin
      n_fail++; $display("FAIL bp_req_stable got %b exp 1", st); end
    n_cmp++; if ({to, nc} !== {1'b0, 32'd8}) begin
      n_fail++; $display("FAIL bp_stall_cycles got %0d (timeout %0d) exp 8", nc, to); end
    n_cmp++; if (fb !== 1'b0) begin
      n_fail++; $display("FAIL bp_early_fwd got %b exp 0", fb); end
    exp = sb_q.pop_front();
    n_cmp++; if (mem_to_wb_bus !== exp) begin
      n_fail++; $display("FAIL bp_result got %h exp %h", mem_to_wb_bus, exp); end
  endtask

  task automatic test_back_to_back();
    int nc; bit st, fb, to; logic [69:0] exp;
    issue(mk(32'h900, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd4, 32'h300, 32'h0),
          {32'h900, 1'b1, 5'd4, 32'h55AA_55AA});
    run_sram(0, 1, 32'h55AA_55AA, nc, st, fb, to);
    exp = sb_q.pop_front();
    // Downstream hold while DONE: next record waits, stray data_ok must be ignored.
    tb_s3 = 1'b1; tb_s4 = 1'b1;
    ex_to_mem_bus = mk(32'h904, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 5'd5, 32'h306, 32'h0);
    for (int c = 0; c < 2; c++) begin
      data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
      @(posedge clk); #1;
      data_data_ok = 1'b0;
      n_cmp++; if ({data_req, stallreq_for_mem, mem_to_wb_bus} !== {2'b00, exp}) begin
        n_fail++; $display("FAIL hold_done[%0d] got %b%b %h exp 00 %h", c, data_req, stallreq_for_mem, mem_to_wb_bus, exp); end
    end
    tb_s3 = 1'b0; tb_s4 = 1'b0;
    sb_q.push_back({32'h904, 1'b1, 5'd5, 32'h0000_C3D4});
    @(posedge clk); #1;
    ex_to_mem_bus = '0;
    n_cmp++; if ({data_req, data_addr, data_size} !== {1'b1, 32'h306, 2'b01}) begin
      n_fail++; $display("FAIL b2b_req got %h exp %h", {data_req, data_addr, data_size}, {1'b1, 32'h306, 2'b01}); end
    run_sram(1, 2, 32'hC3D4_0000, nc, st, fb, to);
    exp = sb_q.pop_front();
    n_cmp++; if ({to, mem_to_wb_bus} !== {1'b0, exp}) begin
      n_fail++; $display("FAIL b2b_result got %h exp %h", mem_to_wb_bus, exp); end
  endtask

  task automatic test_bubble();
    int nc; bit st, fb, to; logic [69:0] exp;
    issue(mk(32'hA00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd6, 32'h400, 32'h0),
          {32'hA00, 1'b1, 5'd6, 32'h7777_0001});
    run_sram(0, 0, 32'h7777_0001, nc, st, fb, to);
    exp = sb_q.pop_front();
    n_cmp++; if (mem_to_wb_bus !== exp) begin
      n_fail++; $display("FAIL bubble_pre got %h exp %h", mem_to_wb_bus, exp); end
    tb_s3 = 1'b1; tb_s4 = 1'b0;
    ex_to_mem_bus = mk(32'hA04, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd8, 32'h404, 32'h0);
    @(posedge clk); #1;
    tb_s3 = 1'b0; ex_to_mem_bus = '0;
    n_cmp++; if ({data_req, stallreq_for_mem, mem_to_wb_bus, mem_to_rf_bus} !== {2'b00, 108'b0}) begin
      n_fail++; $display("FAIL bubble got %b%b %h exp all 0", data_req, stallreq_for_mem, mem_to_wb_bus); end
  endtask

  task automatic test_align();
    int nc; bit st, fb, to;
`ifdef MEM_ALIGN_CHECK_EN
    ex_to_mem_bus = mk(32'hB00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd10, 32'h101, 32'h0);
    @(posedge clk); #1;
    ex_to_mem_bus = '0;
    n_cmp++; if ({mem_excp, data_req, stallreq_for_mem} !== 3'b100) begin
      n_fail++; $display("FAIL align_excp got %b exp 100", {mem_excp, data_req, stallreq_for_mem}); end
    n_cmp++; if ({mem_to_wb_bus[37], mem_to_rf_bus[37]} !== 2'b00) begin
      n_fail++; $display("FAIL align_rfwe got %b exp 00", {mem_to_wb_bus[37], mem_to_rf_bus[37]}); end
    @(posedge clk); #1;
    n_cmp++; if ({mem_excp, data_req} !== 2'b00) begin
      n_fail++; $display("FAIL align_after got %b exp 00", {mem_excp, data_req}); end
    nc = 0; st = 1'b1; fb = 1'b0; to = 1'b0;
`else
    logic [69:0] exp;
    issue(mk(32'hB00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd10, 32'h101, 32'h0),
          {32'hB00, 1'b1, 5'd10, 32'hFEED_0101});
    n_cmp++; if ({mem_excp, data_req, data_addr} !== {2'b01, 32'h101}) begin
      n_fail++; $display("FAIL noalign_req got %h exp %h", {mem_excp, data_req, data_addr}, {2'b01, 32'h101}); end
    run_sram(0, 1, 32'hFEED_0101, nc, st, fb, to);
    exp = sb_q.pop_front();
    n_cmp++; if ({to, mem_to_wb_bus} !== {1'b0, exp}) begin
      n_fail++; $display("FAIL noalign_result got %h exp %h", mem_to_wb_bus, exp); end
`endif
  endtask

  initial begin
    resetn = 1'b0; ex_to_mem_bus = '0; tb_s3 = 1'b0; tb_s4 = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    test_reset();
    test_lw();
    test_load_extend();
    test_store_merge();
    test_non_mem();
    test_backpressure();
    test_back_to_back();
    test_bubble();
    test_align();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
